// File: rtl/pipeline_regs_if.sv
// Bus bundle for pipeline_regs: stage-0 input handshake, per-stage stall/flush controls,
// last-stage output, per-stage valid bits and performance counters.
interface pipeline_regs_if #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [STAGES-1:0] stage_valid;
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_count;
  logic [31:0]       retired_count;

  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, out_valid, out_data, stage_valid,
           stall_cycles, flush_count, retired_count
  );

  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, out_valid, out_data, stage_valid,
           stall_cycles, flush_count, retired_count
  );
endinterface

// File: rtl/pipeline_regs.sv
// STAGES-deep register pipeline with per-stage stall/flush and bubble insertion.
// Define PIPE_PERF_COUNTERS_EN to build the stall/flush/retire counters; otherwise they read 0.
module pipeline_regs #(
  parameter int DATA_W     = 32,
  parameter int STAGES     = 4,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_regs_if.slave bus
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] data_p   [STAGES];
  logic [STAGES-1:0] vld_nxt;
  logic [DATA_W-1:0] data_nxt [STAGES];

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] bubble;
  logic [STAGES-1:0] up_vld;
  logic [DATA_W-1:0] up_data  [STAGES];

  // A stall freezes its own stage and everything upstream; the first moving stage
  // below a frozen one takes a bubble.
  for (genvar i = 0; i < STAGES; i++) begin : g_hold
    assign hold[i] = |bus.stall[STAGES-1:i];
    if (i == 0) begin : g_head
      assign bubble[i] = 1'b0;
    end else begin : g_body
      assign bubble[i] = bus.stall[i-1] & ~hold[i];
    end
  end

  assign up_vld = {vld_p[STAGES-2:0], bus.in_valid};

  always_comb begin
    up_data[0] = bus.in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_data[i] = data_p[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      vld_nxt[i]  = vld_p[i];
      data_nxt[i] = data_p[i];
      if (bus.flush[i] || bubble[i]) begin
        vld_nxt[i] = 1'b0;
        if (CLEAR_DATA) begin
          data_nxt[i] = '0;
        end
      end else if (!hold[i]) begin
        vld_nxt[i]  = up_vld[i];
        data_nxt[i] = up_data[i];
      end
    end
  end

  // Stage registers; payload is cleared on reset too so out_data reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_p[i] <= '0;
      end
    end else begin
      vld_p <= vld_nxt;
      for (int i = 0; i < STAGES; i++) begin
        data_p[i] <= data_nxt[i];
      end
    end
  end

  assign bus.in_ready    = ~hold[0];
  assign bus.out_valid   = vld_p[STAGES-1];
  assign bus.out_data    = data_p[STAGES-1];
  assign bus.stage_valid = vld_p;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_p0;
  logic [31:0] flush_cnt_p0;
  logic [31:0] retire_cnt_p0;

  function automatic logic [31:0] count_flushed(input logic [STAGES-1:0] fl,
                                                input logic [STAGES-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < STAGES; i++) begin
      n = n + {31'd0, fl[i] & v[i]};
    end
    return n;
  endfunction

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_p0  <= '0;
      flush_cnt_p0  <= '0;
      retire_cnt_p0 <= '0;
    end else begin
      stall_cnt_p0  <= stall_cnt_p0 + {31'd0, |bus.stall};
      flush_cnt_p0  <= flush_cnt_p0 + count_flushed(bus.flush, vld_p);
      retire_cnt_p0 <= retire_cnt_p0 + {31'd0, vld_p[STAGES-1] & ~bus.stall[STAGES-1]};
    end
  end

  assign bus.stall_cycles  = stall_cnt_p0;
  assign bus.flush_count   = flush_cnt_p0;
  assign bus.retired_count = retire_cnt_p0;
`else
  assign bus.stall_cycles  = '0;
  assign bus.flush_count   = '0;
  assign bus.retired_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed plus randomized bench for pipeline_regs (STAGES=4, DATA_W=32, CLEAR_DATA=1)
// against a slot-array reference model keyed on the deepest stalled stage.
module tb_pipeline_regs;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_regs_if #(.DATA_W(32), .STAGES(S)) bus ();

  pipeline_regs #(.DATA_W(32), .STAGES(S), .CLEAR_DATA(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_v [S];
  logic [31:0] m_d [S];
  logic [31:0] m_stall, m_flush, m_retire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef PIPE_PERF_COUNTERS_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_stall  = '0;
    m_flush  = '0;
    m_retire = '0;
  endtask

  // Everything above the deepest stalled stage shifts down, the stage just below it
  // gets a bubble, the rest stay put; flushes are then applied on top.
  task automatic model_step();
    int          k;
    bit          nv [S];
    logic [31:0] nd [S];
    k = -1;
    for (int i = 0; i < S; i++) if (bus.stall[i]) k = i;
    if (k >= 0) m_stall++;
    if (m_v[S-1] && !bus.stall[S-1]) m_retire++;
    for (int i = 0; i < S; i++) if (bus.flush[i] && m_v[i]) m_flush++;
    for (int i = 0; i < S; i++) begin
      if (i <= k) begin
        nv[i] = m_v[i]; nd[i] = m_d[i];
      end else if (k >= 0 && i == k + 1) begin
        nv[i] = 1'b0; nd[i] = '0;
      end else if (i == 0) begin
        nv[i] = bus.in_valid; nd[i] = bus.in_data;
      end else begin
        nv[i] = m_v[i-1]; nd[i] = m_d[i-1];
      end
      if (bus.flush[i]) begin
        nv[i] = 1'b0; nd[i] = '0;
      end
    end
    for (int i = 0; i < S; i++) begin
      m_v[i] = nv[i];
      m_d[i] = nd[i];
    end
  endtask

  task automatic check_all();
    logic [31:0] sv;
    sv = '0;
    for (int i = 0; i < S; i++) sv[i] = m_v[i];
    check("stage_valid", {28'd0, bus.stage_valid}, sv);
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_v[S-1]});
    check("out_data", bus.out_data, m_d[S-1]);
    check("stall_cycles", bus.stall_cycles, cexp(m_stall));
    check("flush_count", bus.flush_count, cexp(m_flush));
    check("retired_count", bus.retired_count, cexp(m_retire));
  endtask

  task automatic tick();
    #1;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, (bus.stall == '0)});
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.stall    = '0;
    bus.flush    = '0;
    model_reset();

    // Reset state and in_ready following stall during reset
    #1;
    check("rst_stage_valid", {28'd0, bus.stage_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    bus.stall = 4'b0100;
    #1 check("rst_in_ready_stalled", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    tick();
    bus.stall = '0;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Streaming with fixed 4-cycle latency
    for (int n = 1; n <= 8; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = n;
      tick();
      if (n >= 4) check("stream_out", bus.out_data, n - 3);
      check("stream_retired", bus.retired_count, cexp((n > 4) ? n - 4 : 0));
    end

    // Single-cycle stall on stage 1 with a full pipe
    bus.stall   = 4'b0010;
    bus.in_data = 9;
    #1 check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("stall_bubble_valid", {28'd0, bus.stage_valid}, 32'b1011);
    check("stall_bubble_out", bus.out_data, 32'd6);
    check("stall_cycles_one", bus.stall_cycles, cexp(32'd1));
    bus.stall = '0;
    for (int n = 10; n <= 12; n++) begin
      bus.in_data = n;
      tick();
    end

    // Flush wins over stall on the same stage
    bus.flush   = 4'b0011;
    bus.stall   = 4'b0001;
    bus.in_data = 13;
    tick();
    check("flush_prio_valid", {28'd0, bus.stage_valid}, 32'b1100);
    check("flush_prio_count", bus.flush_count, cexp(32'd2));
    check("flush_prio_out", bus.out_data, 32'd10);
    bus.flush    = '0;
    bus.stall    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick();
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 20;
    tick();

    // Flush of an empty last stage does not count
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 4'b1000;
    tick();
    check("flush_empty_valid", {28'd0, bus.stage_valid}, 32'b0010);
    check("flush_empty_count", bus.flush_count, cexp(32'd2));
    bus.flush = '0;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = bus.in_valid ? $urandom : 32'd0;
      for (int i = 0; i < S; i++) begin
        bus.stall[i] = ($urandom_range(0, 7) == 0);
        bus.flush[i] = ($urandom_range(0, 11) == 0);
      end
      tick();
    end

    // Fill, then asynchronous reset between edges
    bus.stall    = '0;
    bus.flush    = '0;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      bus.in_data = $urandom | 32'd1;
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check("arst_stage_valid", {28'd0, bus.stage_valid}, 32'd0);
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_out_data", bus.out_data, 32'd0);
    check("arst_stall_cycles", bus.stall_cycles, 32'd0);
    check("arst_flush_count", bus.flush_count, 32'd0);
    check("arst_retired", bus.retired_count, 32'd0);
    model_reset();
    bus.stall = 4'b0100;
    tick();
    bus.stall = '0;
    tick();
    rst = 1'b0;

    // Streaming resumes cleanly after reset
    for (int n = 1; n <= 6; n++) begin
      bus.in_data = 32'h100 + n;
      tick();
      if (n >= 4) check("post_rst_out", bus.out_data, 32'h100 + n - 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_regs.md
PIPELINE_REGS -- requirements
Module: pipeline_regs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width per stage.
REQ-002 SHALL have parameter STAGES, default 4, number of register stages (legal 2..8).
REQ-003 SHALL have parameter CLEAR_DATA, default 1: when 1, bubbles and flushed stages carry all-zero data.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  stage-0 input carries a valid payload.
REQ-007 SHALL have port in_data  input  DATA_W  stage-0 input payload.
REQ-008 SHALL have port stall  input  STAGES  stall[i] = stage i requests a hold.
REQ-009 SHALL have port flush  input  STAGES  flush[i] = invalidate stage i.
REQ-010 SHALL have port in_ready  output  1  stage 0 accepts in_data this cycle.
REQ-011 SHALL have port out_valid  output  1  valid bit of last stage.
REQ-012 SHALL have port out_data  output  DATA_W  payload of last stage.
REQ-013 SHALL have port stage_valid  output  STAGES  per-stage valid bits.
REQ-014 SHALL have ports stall_cycles, flush_count, retired_count  output  32 each  performance counters (see Configuration).

Function
REQ-015 Each stage i SHALL hold a valid bit V[i] and payload D[i]; outputs are registered, no combinational in-to-out path.
REQ-016 hold[i] SHALL equal OR of stall[j] for j >= i (a stall freezes its own stage and all upstream stages).
REQ-017 in_ready SHALL equal NOT hold[0].
REQ-018 Per edge, stage i priority: flush[i] -> V[i]=0 (D[i]=0 if CLEAR_DATA); else hold[i] -> V[i], D[i] unchanged; else load from stage i-1 (stage 0 loads in_valid, in_data).
REQ-019 If hold[i-1]=1 and hold[i]=0, stage i SHALL load a bubble: V[i]=0, D[i]=0 if CLEAR_DATA else unchanged.
REQ-020 Latency with no stall/flush SHALL be exactly STAGES cycles from in_valid sample to out_valid.
REQ-021 Flush and stall asserted on the same stage in the same cycle: flush SHALL win; upstream stages still hold.
REQ-022 A flushed stage with valid payload SHALL increment flush_count by 1; flush of an empty stage SHALL NOT count.
REQ-023 in_valid presented while in_ready=0 SHALL be ignored (no capture, no error).
REQ-024 stall_cycles SHALL increment by 1 every cycle where any stall bit is set; retired_count SHALL increment every cycle where out_valid=1 and stall[STAGES-1]=0.
REQ-025 All counters SHALL wrap modulo 2^32.

Reset
REQ-026 On rst=1, all V[i], D[i], and counters SHALL clear to 0 asynchronously; out_valid=0, out_data=0, stage_valid=0.
REQ-027 in_ready SHALL follow stall combinationally during reset; no capture occurs while rst=1.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight payloads with no counter updates.

Configuration
REQ-029 Macro PIPE_PERF_COUNTERS_EN SHALL gate performance counters.
REQ-030 With PIPE_PERF_COUNTERS_EN defined, counters SHALL behave per REQ-022, REQ-024, REQ-025.
REQ-031 Without it, the counter ports SHALL exist and be tied to constant 0, with no counter flops synthesised.

Verification (STAGES=4, DATA_W=32, CLEAR_DATA=1, PIPE_PERF_COUNTERS_EN defined)
REQ-032 Streaming: in_valid=1, in_data=1,2,3,... no stall/flush -> out_data=1 on cycle 4 after first sample, then 2,3 consecutively; retired_count increments each cycle.
REQ-033 Stall bubble: stall=4'b0010 for 1 cycle with stages full -> stages 0,1 hold, in_ready=0, stage 2 receives V=0 D=0, stall_cycles=1.
REQ-034 Flush priority: flush=4'b0011, stall=4'b0001 with stages 0,1 valid -> stage_valid[1:0]=00, flush_count+=2, stage 0 data=0.
REQ-035 Flush of empty stage: flush=4'b1000 with V[3]=0 -> flush_count unchanged.
REQ-036 Reset mid-stream: rst pulsed asynchronously between edges with all stages valid -> stage_valid=0, out_data=0, all counters=0 immediately.
REQ-037 Macro undefined build: repeat REQ-032 -> identical data behaviour, all counter ports read 0.
